// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int WAIT_W = 4;
endpackage

// File: rtl/ld_extend.sv
// ld_extend: lane select and sign/zero extension of a RAM word for loads.
module ld_extend
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  size_t       size,
    input  logic        uns,
    output logic [31:0] data
);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        shifted = word >> {off, 3'b000};
        b = shifted[7:0];
        h = off[1] ? word[31:16] : word[15:0];
        data = size == SZ_BYTE ? {{24{~uns & b[7]}}, b} :
               size == SZ_HALF ? {{16{~uns & h[15]}}, h} : word;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated byte/half/word RAM behind valid/ready request and response channels.
// Define MISALIGN_TRAP_EN to trap misaligned accesses with rsp_err instead of forcing alignment.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);
    state_t            state, state_nx;
    logic [WAIT_W-1:0] cnt;
    logic              we_q, uns_q;
    size_t             sz_q;
    logic [AW+1:0]     addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       ld_data, st_data;
    logic [3:0]        be;
    logic              mis, access;
    assign access = state == WAIT && cnt == '0;
`ifdef MISALIGN_TRAP_EN
    assign mis = (sz_q == SZ_HALF && addr_q[0]) || (sz_q == SZ_WORD && addr_q[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? (req_valid ? WAIT : IDLE) :
                   state == WAIT ? (cnt == '0 ? RESP : WAIT) :
                   (rsp_ready ? IDLE : RESP);
    end
    always_comb begin
        req_ready = state == IDLE;
        rsp_valid = state == RESP;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            sz_q      <= SZ_BYTE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                cnt     <= WAIT_W'(WAIT_CYCLES);
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                sz_q    <= req_size == 2'b11 ? SZ_WORD : size_t'(req_size);
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access) begin
                rsp_rdata <= (we_q || mis) ? 32'h0 : ld_data;
                rsp_err   <= mis;
            end
        end
    end
    // Byte enables and lane replication place the right-justified store data on the addressed lanes.
    always_comb begin
        be = sz_q == SZ_BYTE ? 4'b0001 << addr_q[1:0] :
             sz_q == SZ_HALF ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        st_data = sz_q == SZ_BYTE ? {4{wdata_q[7:0]}} :
                  sz_q == SZ_HALF ? {2{wdata_q[15:0]}} : wdata_q;
    end
    always_ff @(posedge clk) begin
        if (access && we_q && !mis)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= st_data[8*i +: 8];
    end
    ld_extend u_ld_extend (
        .word (mem[addr_q[AW+1:2]]),
        .off  (addr_q[1:0]),
        .size (sz_q),
        .uns  (uns_q),
        .data (ld_data)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks on a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we [2];
    logic [1:0]  req_size [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err [2];
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );
    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask
    // Present a request before the edge; returns after the acceptance edge with req_valid dropped.
    task automatic issue(input int d, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        check("ready_before_accept", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d] = we;
        req_size[d] = sz;
        req_unsigned[d] = uns;
        req_addr[d] = addr;
        req_wdata[d] = wdata;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
    endtask
    // Count edges until rsp_valid, then handshake; edges counts from the acceptance edge.
    task automatic finish(input int d, output logic [31:0] rdata, output logic err, output int edges);
        edges = 0;
        while (!rsp_valid[d] && edges < 40) begin
            @(posedge clk);
            #1 edges++;
        end
        rdata = rsp_rdata[d];
        err = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[d] = 1'b0;
        check("valid_after_handshake", 32'(rsp_valid[d]), 32'd0);
    endtask
    task automatic access(input int d, input string tag, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input logic exp_err, input int exp_edges);
        logic [31:0] r;
        logic e;
        int n;
        issue(d, we, sz, uns, addr, wdata);
        finish(d, r, e, n);
        check({tag, "_data"}, r, exp);
        check({tag, "_err"}, 32'(e), 32'(exp_err));
        check({tag, "_edges"}, n, exp_edges);
    endtask
    initial begin
        logic [31:0] r;
        logic e;
        int n;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i] = 1'b0;
            req_size[i] = 2'b00;
            req_unsigned[i] = 1'b0;
            req_addr[i] = '0;
            req_wdata[i] = '0;
            rsp_ready[i] = 1'b0;
        end
        #23;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(req_ready[i]), 32'd1);
            check("rst_valid", 32'(rsp_valid[i]), 32'd0);
            check("rst_rdata", rsp_rdata[i], 32'h0);
            check("rst_err", 32'(rsp_err[i]), 32'd0);
        end
        @(negedge clk) reset_n = 1'b1;
        // Store discarded by a reset arriving during WAIT.
        access(0, "sw_pre", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 3);
        issue(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hFFFFFFFF);
        reset_n = 1'b0;
        #1 check("rstwait_valid", 32'(rsp_valid[0]), 32'd0);
        check("rstwait_ready", 32'(req_ready[0]), 32'd1);
        repeat (3) @(posedge clk);
        #1 check("rstwait_valid2", 32'(rsp_valid[0]), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        access(0, "lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h11223344, 1'b0, 3);
        access(0, "sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 32'h0, 1'b0, 3);
        access(0, "lb_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 3);
        access(0, "lbu_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000AA, 1'b0, 3);
        access(0, "lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 3);
        access(0, "lhu_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00008899, 1'b0, 3);
        access(0, "lh_10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 3);
        access(0, "sb_13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345655, 32'h0, 1'b0, 3);
        access(0, "lw_10", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h5599AABB, 1'b0, 3);
        access(0, "lb_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000055, 1'b0, 3);
        access(0, "sz11_10", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h5599AABB, 1'b0, 3);
        // Backpressure: response held five cycles while a second request waits.
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        n = 0;
        while (!rsp_valid[0] && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check("bp_edges", n, 3);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0] = 1'b0;
        req_size[0] = 2'b00;
        req_unsigned[0] = 1'b1;
        req_addr[0] = 32'h12;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_rdata", rsp_rdata[0], 32'h5599AABB);
            check("bp_ready", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        check("bp_idle_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        check("bp_second_accepted", 32'(req_ready[0]), 32'd0);
        finish(0, r, e, n);
        check("bp_second_data", r, 32'h00000099);
        check("bp_second_edges", n, 3);
`ifdef MISALIGN_TRAP_EN
        access(0, "lw_12_trap", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 3);
        access(0, "sw_11_trap", 1'b1, 2'b10, 1'b0, 32'h11, 32'hCAFEF00D, 32'h0, 1'b1, 3);
        access(0, "lh_11_trap", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 3);
        access(0, "lw_10_kept", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h5599AABB, 1'b0, 3);
`else
        access(0, "lw_12_align", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h5599AABB, 1'b0, 3);
        access(0, "lh_13_align", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h00005599, 1'b0, 3);
`endif
        // Zero wait states and address aliasing on the second instance.
        access(1, "sw_100", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1);
        access(1, "lw_000", 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'hDEADBEEF, 1'b0, 1);
        access(1, "lhu_102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000DEAD, 1'b0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the core's data-memory request interface. It accepts one load or store at a time over a valid/ready request channel and performs byte, halfword or word access into an internal word-organised RAM after a programmable number of wait states. It returns sign- or zero-extended load data over a valid/ready response channel. It sits behind the MIPS datapath's memory stage and replaces the single-cycle combinational data memory when wait states must be modelled.

## Interface
- DEPTH, 64: RAM size in 32-bit words; power of two, at least 2.
- WAIT_CYCLES, 2: extra access wait states; 0 to 15.

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned access (only with the trap feature)

## Operation
- The request is accepted on a rising edge with req_valid && req_ready. All request fields are latched on that edge.
- Word index is req_addr[$clog2(DEPTH)+1:2]. Upper address bits are ignored, so addresses alias.
- Byte order is little-endian: addr[1:0]=0 selects bits [7:0].
- Store: write only the addressed lanes with the low byte or half of req_wdata steered to them. Other lanes are unchanged.
- Load: select the lanes, then extend them to 32 bits according to req_unsigned. A word load ignores req_unsigned.
- FSM states:
  - IDLE: req_ready=1. On acceptance, load wait counter with WAIT_CYCLES and go to WAIT.
  - WAIT: req_ready=0. If count != 0, decrement. If count == 0, perform the RAM write or capture the extended read data on this edge, then go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable. When rsp_ready=1, go to IDLE.
- No request is accepted in WAIT or RESP. req_valid there is ignored and the requester must hold it.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0. RAM contents are not reset.
- Reset asserted in WAIT: a pending store is discarded and RAM is not modified. Reset asserted in RESP: the response is dropped.

## Timing
- Acceptance edge E0. RAM access at edge E0+WAIT_CYCLES+1. rsp_valid is high from just after that edge.
- The response handshake happens at the earliest on edge E0+WAIT_CYCLES+2. IDLE follows, and the next acceptance is no earlier than E0+WAIT_CYCLES+3.
- Maximum throughput is one access per WAIT_CYCLES+3 cycles.
- When rsp_ready is held high, rsp_valid lasts exactly one cycle.
- Response outputs are registered. No combinational path runs from request inputs to response outputs.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]!=0, is misaligned.
  - A misaligned access makes no RAM change and responds with rsp_err=1 and rsp_rdata=0. Latency is unchanged.
- MISALIGN_TRAP_EN undefined:
  - Offending low address bits are forced to zero: a halfword uses addr[1], a word uses addr[1:0]=0.
  - rsp_err is tied to 0.

## Structure
- Package dmem_pkg:
  - size_t enum: SZ_BYTE, SZ_HALF, SZ_WORD.
  - state_t enum: IDLE, WAIT, RESP.
  - Constant WAIT_W=4.
- Sub-module ld_extend, purely combinational: inputs are the 32-bit word, addr[1:0], size and unsigned; output is the lane-selected, extended 32-bit value.
- Store lane steering and byte enables stay in the top module.

## Test plan
- Reset mid-WAIT: issue a store, deassert reset_n in WAIT, then load the same address. RAM must be unchanged, and rsp_valid must be low during reset with req_ready=1.
- Word store and loads, WAIT_CYCLES=2:
  - Store word 0x8899AABB at 0x10. rsp_valid must go high 3 edges after acceptance, with rsp_rdata=0.
  - lb 0x11 -> 0xFFFFFFAA.
  - lbu 0x11 -> 0x000000AA.
  - lh 0x12 -> 0xFFFF8899.
  - lhu 0x12 -> 0x00008899.
- Byte store: sb 0x13 with wdata=0x12345655, then lw 0x10 -> 0x5599AABB.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. rsp_valid, rsp_rdata and req_ready=0 must stay stable, and a second req_valid must not be accepted until after the response handshake.
- Misaligned: lw 0x12 after the above. With MISALIGN_TRAP_EN, expect rsp_err=1 and rsp_rdata=0; a store sw 0x11 must leave RAM unchanged. Without the macro, lw 0x12 returns the word at 0x10 and rsp_err=0.
- WAIT_CYCLES=0 and aliasing: with DEPTH=64, store 0xDEADBEEF at 0x100, then lw 0x000 -> 0xDEADBEEF, with rsp_valid high 1 edge after acceptance.
